// File: rtl/alib_ram_rd_stream.sv
// rtl/alib_ram_rd_stream.sv - RAM read initiator emitting a valid/ready word stream (optional ALIB_RAM_RD_STREAM_STRIDE_EN)
module alib_ram_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
`ifdef ALIB_RAM_RD_STREAM_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_en,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     issued;
    logic                    inflight;
    logic                    inflight_last;
    logic [1:0]              fifo_count;
    logic [DATA_WIDTH-1:0]   slot1_data;
    logic                    slot1_last;
    logic [ADDR_WIDTH-1:0]   step;

`ifdef ALIB_RAM_RD_STREAM_STRIDE_EN
    logic [ADDR_WIDTH-1:0]   step_q;
    assign step = step_q;
`else
    assign step = ADDR_WIDTH'(1);
`endif

    logic                    pop;
    logic                    push;
    logic                    issue;
    logic [2:0]              occ;
    logic [1:0]              count_next;
    logic [ADDR_WIDTH:0]     issued_next;
    logic                    run_end;
    logic [ADDR_WIDTH:0]     addr_sum;
    logic [ADDR_WIDTH-1:0]   addr_next;

    // Issue/occupancy bookkeeping: a read may only be launched if its word is guaranteed a FIFO slot
    always_comb begin
        pop         = m_valid && m_ready;
        push        = inflight;
        occ         = {1'b0, fifo_count} + {2'b00, inflight};
        issue       = (state == RUN) && (issued < len_q) && (occ < (pop ? 3'd3 : 3'd2));
        count_next  = fifo_count + {1'b0, push} - {1'b0, pop};
        issued_next = issued + {{ADDR_WIDTH{1'b0}}, issue};
        // Finish as soon as the post-edge state is drained so done lands the cycle after the last beat
        run_end     = (issued_next == len_q) && !issue && (count_next == 2'd0);
        addr_sum    = {1'b0, ram_addr} + {1'b0, step};
        addr_next   = (addr_sum >= DEPTH_W) ? ADDR_WIDTH'(addr_sum - DEPTH_W)
                                            : ADDR_WIDTH'(addr_sum);
    end

    // Control FSM with registered status outputs and the RAM address walker
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            ram_en        <= 1'b0;
            ram_addr      <= '0;
            len_q         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
`ifdef ALIB_RAM_RD_STREAM_STRIDE_EN
            step_q        <= '0;
`endif
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (issued_next == len_q);
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q    <= length;
                        ram_addr <= base_addr;
                        issued   <= '0;
`ifdef ALIB_RAM_RD_STREAM_STRIDE_EN
                        step_q   <= stride;
`endif
                        busy     <= 1'b1;
                        if (length != '0) begin
                            state  <= RUN;
                            ram_en <= 1'b1;
                        end else begin
                            state  <= FIN;
                            done   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        ram_addr <= addr_next;
                        issued   <= issued_next;
                    end
                    if (run_end) begin
                        state  <= FIN;
                        ram_en <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    ram_en <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry output FIFO; the head entry drives the stream directly so it holds under stall
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_count <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            slot1_data <= '0;
            slot1_last <= 1'b0;
        end else begin
            fifo_count <= count_next;
            m_valid    <= (count_next != 2'd0);
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        m_data <= ram_dout;
                        m_last <= inflight_last;
                    end else begin
                        slot1_data <= ram_dout;
                        slot1_last <= inflight_last;
                    end
                end
                2'b01: begin
                    m_data <= slot1_data;
                    m_last <= slot1_last;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        m_data <= ram_dout;
                        m_last <= inflight_last;
                    end else begin
                        m_data     <= slot1_data;
                        m_last     <= slot1_last;
                        slot1_data <= ram_dout;
                        slot1_last <= inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alib_ram_rd_stream.sv
// tb/tb_alib_ram_rd_stream.sv - self-checking bench for alib_ram_rd_stream
module tb_alib_ram_rd_stream;

    localparam int DW    = 8;
    localparam int DEPTH = 10;
    localparam int AW    = $clog2(DEPTH - 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
`ifdef ALIB_RAM_RD_STREAM_STRIDE_EN
    logic [AW-1:0] stride;
`endif
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic          ram_en;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;

    logic [DW-1:0] mem [0:15];
    logic [DW:0]   sb [$];

    int n_vec = 0;
    int n_err = 0;
    int beats = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    alib_ram_rd_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
`ifdef ALIB_RAM_RD_STREAM_STRIDE_EN
        .stride(stride),
`endif
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_en(ram_en), .ram_dout(ram_dout),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model, output enable gated by ram_en
    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample the stream at the falling edge, then advance to just after the next rising edge
    task automatic tick();
        logic [DW:0] e;
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, m_valid}, 32'd1);
                check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
                check("stall_last", {31'd0, m_last}, {31'd0, prev_last});
            end
            if (m_valid && m_ready) begin
                n_vec++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_extra: observed beat %0h expected none", {m_last, m_data});
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("beat", {23'd0, m_last, m_data}, {23'd0, e});
                end
                beats++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
        @(posedge clk);
        #1;
    endtask

    // Push the expected beats, then present start for one cycle
    task automatic do_start(input int b, input int len, input int st);
        int a;
        a = b;
        for (int k = 0; k < len; k++) begin
            sb.push_back({(k == len - 1), mem[a]});
            a = a + st;
            if (a >= DEPTH) a = a - DEPTH;
        end
        base_addr = AW'(b);
        length    = (AW + 1)'(len);
`ifdef ALIB_RAM_RD_STREAM_STRIDE_EN
        stride    = AW'(st);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, input bit rnd, input bit inject);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (!seen) begin
                if (rnd) m_ready = 1'($urandom_range(0, 1));
                if (inject && i == 4) begin
                    start = 1'b1; base_addr = AW'(5); length = (AW + 1)'(2);
                end else begin
                    start = 1'b0;
                end
                tick();
                if (done) seen = 1'b1;
            end
        end
        start = 1'b0;
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int b0;
        for (int i = 0; i < 16; i++) mem[i] = DW'(i * 16 + 5);
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
`ifdef ALIB_RAM_RD_STREAM_STRIDE_EN
        stride = AW'(1);
`endif
        tick(); tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_last", {31'd0, m_last}, 32'd0);
        check("rst_addr", {28'd0, ram_addr}, 32'd0);
        check("rst_data", {24'd0, m_data}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic latency: base 0, length 4, full ready
        do_start(0, 4, 1);
        check("t1_c1_addr", {28'd0, ram_addr}, 32'd0);
        check("t1_c1_busy", {31'd0, busy}, 32'd1);
        check("t1_c1_ram_en", {31'd0, ram_en}, 32'd1);
        check("t1_c1_valid", {31'd0, m_valid}, 32'd0);
        tick(); tick();
        check("t1_c3_valid", {31'd0, m_valid}, 32'd1);
        check("t1_c3_last", {31'd0, m_last}, 32'd0);
        tick(); tick(); tick();
        check("t1_c6_last", {31'd0, m_last}, 32'd1);
        check("t1_c6_done", {31'd0, done}, 32'd0);
        tick();
        check("t1_c7_done", {31'd0, done}, 32'd1);
        check("t1_c7_valid", {31'd0, m_valid}, 32'd0);
        check("t1_c7_ram_en", {31'd0, ram_en}, 32'd0);
        tick();
        check("t1_c8_busy", {31'd0, busy}, 32'd0);
        check("t1_c8_done", {31'd0, done}, 32'd0);
        check("t1_sb_empty", sb.size(), 32'd0);

        // Address wrap: base 8, length 4 -> 8,9,0,1
        do_start(8, 4, 1);
        check("t2_c1_addr", {28'd0, ram_addr}, 32'd8);
        wait_done("t2_done", 30, 1'b0, 1'b0);
        tick();
        check("t2_sb_empty", sb.size(), 32'd0);

        // Random backpressure, 16 beats with wrap, spurious start while busy
        b0 = beats;
        do_start(3, 16, 1);
        wait_done("t3_done", 300, 1'b1, 1'b1);
        m_ready = 1'b1;
        tick();
        check("t3_sb_empty", sb.size(), 32'd0);
        check("t3_beats", beats - b0, 32'd16);
        check("t3_idle", {31'd0, busy}, 32'd0);

        // Zero length: no beats, done one cycle after start
        b0 = beats;
        do_start(0, 0, 1);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_ram_en", {31'd0, ram_en}, 32'd0);
        check("t4_valid", {31'd0, m_valid}, 32'd0);
        tick();
        check("t4_done_pulse", {31'd0, done}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_beats", beats - b0, 32'd0);

        // Reset mid-transfer after 3 of 8 beats
        b0 = beats;
        do_start(0, 8, 1);
        for (int i = 0; i < 30; i++) begin
            if (beats - b0 < 3) tick();
        end
        check("t5_three_beats", beats - b0, 32'd3);
        rst = 1'b1; m_ready = 1'b0;
        tick();
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_ram_en", {31'd0, ram_en}, 32'd0);
        check("t5_valid", {31'd0, m_valid}, 32'd0);
        check("t5_last", {31'd0, m_last}, 32'd0);
        check("t5_addr", {28'd0, ram_addr}, 32'd0);
        check("t5_data", {24'd0, m_data}, 32'd0);
        rst = 1'b0; m_ready = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_done", {31'd0, done}, 32'd0);
        end
        b0 = beats;
        do_start(2, 8, 1);
        wait_done("t5_restart_done", 40, 1'b0, 1'b0);
        tick();
        check("t5_restart_beats", beats - b0, 32'd8);
        check("t5_sb_empty", sb.size(), 32'd0);

`ifdef ALIB_RAM_RD_STREAM_STRIDE_EN
        // Stride 3 from 7 wraps to 0, then 3
        do_start(7, 3, 3);
        check("t6_c1_addr", {28'd0, ram_addr}, 32'd7);
        wait_done("t6_done", 30, 1'b0, 1'b0);
        tick();
        check("t6_sb_empty", sb.size(), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
